// File: rtl/dma_pkg.sv
// Shared definitions for the DMA channel sequencer: FSM states and
// fixed datapath/descriptor geometry.
package dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_RD_CMD    = 3'd2,
        ST_WR_CMD    = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_BUF_DONE  = 3'd5,
        ST_FETCH     = 3'd6
    } state_t;

    localparam int DMA_BEAT_BYTES   = 4;
    localparam int DESC_ALIGN_SHIFT = 4;
    localparam int BEAT_SHIFT       = 2;

endpackage

// File: rtl/dma_burst_split.sv
// Burst splitter: clamps the remaining beat count to MAX_BURST and walks the
// read/write addresses forward one burst at a time.
module dma_burst_split #(
    parameter int MAX_BURST  = 16,
    parameter int BEAT_BYTES = 4,
    parameter int LEN_W      = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             advance,
    input  logic [31:0]      rd_start_addr,
    input  logic [31:0]      wr_start_addr,
    input  logic [29:0]      size_beats,
    output logic [31:0]      rd_addr,
    output logic [31:0]      wr_addr,
    output logic [LEN_W-1:0] burst_len,
    output logic             last_burst
);

    logic [31:0] rd_addr_reg;
    logic [31:0] wr_addr_reg;
    logic [29:0] remaining_reg;
    logic [31:0] step;

    always_comb begin
        burst_len = remaining_reg[LEN_W-1:0];
        if (remaining_reg >= 30'(MAX_BURST))
            burst_len = LEN_W'(MAX_BURST);
        step       = 32'(burst_len) * 32'(BEAT_BYTES);
        last_burst = (remaining_reg == 30'(burst_len));
    end

    // Load takes priority; the FSM never asserts both in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_addr_reg   <= '0;
            wr_addr_reg   <= '0;
            remaining_reg <= '0;
        end else if (load) begin
            rd_addr_reg   <= rd_start_addr;
            wr_addr_reg   <= wr_start_addr;
            remaining_reg <= size_beats;
        end else if (advance) begin
            rd_addr_reg   <= rd_addr_reg + step;
            wr_addr_reg   <= wr_addr_reg + step;
            remaining_reg <= remaining_reg - 30'(burst_len);
        end
    end

    assign rd_addr = rd_addr_reg;
    assign wr_addr = wr_addr_reg;

endmodule

// File: rtl/dma_ch_ctrl.sv
// DMA channel sequencer: turns regfile descriptors into read/write burst
// commands, follows descriptor chains and reports completion counters.
module dma_ch_ctrl
    import dma_pkg::*;
#(
    parameter int MAX_BURST  = 16,
    parameter int BEAT_BYTES = DMA_BEAT_BYTES,
    parameter int LEN_W      = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      rd_start_addr,
    input  logic [31:0]      wr_start_addr,
    input  logic [31:0]      buffer_size,
    input  logic             set_int,
    input  logic             cmd_last,
    input  logic [27:0]      next_addr,
    input  logic             wr_ch_start,
    output logic [15:0]      buffer_count,
    output logic [15:0]      int_count,
    output logic             irq,
    output logic             busy,
    output logic             rd_cmd_valid,
    input  logic             rd_cmd_ready,
    output logic [31:0]      rd_cmd_addr,
    output logic [LEN_W-1:0] rd_cmd_len,
    output logic             wr_cmd_valid,
    input  logic             wr_cmd_ready,
    output logic [31:0]      wr_cmd_addr,
    output logic [LEN_W-1:0] wr_cmd_len,
    input  logic             wr_done,
    output logic             cmd_fetch_req,
    output logic [31:0]      cmd_fetch_addr,
    input  logic             cmd_fetch_ack
);

    state_t      state_reg, state_next;
    logic        desc_load;
    logic        split_advance;
    logic        set_int_reg;
    logic        cmd_last_reg;
    logic [27:0] next_addr_reg;
    logic [15:0] buffer_count_reg;
    logic [15:0] int_count_reg;
    logic [LEN_W-1:0] burst_len;
    logic        last_burst;
    logic        size_zero;
    logic        unused_size_bits;

    assign size_zero        = (buffer_size[31:BEAT_SHIFT] == '0);
    assign unused_size_bits = ^buffer_size[BEAT_SHIFT-1:0];

    dma_burst_split #(
        .MAX_BURST  (MAX_BURST),
        .BEAT_BYTES (BEAT_BYTES),
        .LEN_W      (LEN_W)
    ) u_split (
        .clk           (clk),
        .reset         (reset),
        .load          (desc_load),
        .advance       (split_advance),
        .rd_start_addr (rd_start_addr),
        .wr_start_addr (wr_start_addr),
        .size_beats    (buffer_size[31:BEAT_SHIFT]),
        .rd_addr       (rd_cmd_addr),
        .wr_addr       (wr_cmd_addr),
        .burst_len     (burst_len),
        .last_burst    (last_burst)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next    = state_reg;
        desc_load     = 1'b0;
        split_advance = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (wr_ch_start) begin
                    desc_load  = 1'b1;
                    state_next = size_zero ? ST_BUF_DONE : ST_RD_CMD;
                end
            end
            ST_LOAD: begin
                desc_load  = 1'b1;
                state_next = size_zero ? ST_BUF_DONE : ST_RD_CMD;
            end
            ST_RD_CMD:    if (rd_cmd_ready) state_next = ST_WR_CMD;
            ST_WR_CMD:    if (wr_cmd_ready) state_next = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (wr_done) begin
                    split_advance = 1'b1;
                    state_next    = last_burst ? ST_BUF_DONE : ST_RD_CMD;
                end
            end
            ST_BUF_DONE:  state_next = cmd_last_reg ? ST_IDLE : ST_FETCH;
            ST_FETCH:     if (cmd_fetch_ack) state_next = ST_LOAD;
            default:      state_next = ST_IDLE;
        endcase
    end

    // Descriptor attributes are captured together with the addresses/size.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            set_int_reg      <= 1'b0;
            cmd_last_reg     <= 1'b0;
            next_addr_reg    <= '0;
            buffer_count_reg <= '0;
            int_count_reg    <= '0;
        end else begin
            if (desc_load) begin
                set_int_reg   <= set_int;
                cmd_last_reg  <= cmd_last;
                next_addr_reg <= next_addr;
            end
            if (state_reg == ST_BUF_DONE) begin
                buffer_count_reg <= buffer_count_reg + 16'd1;
                if (set_int_reg)
                    int_count_reg <= int_count_reg + 16'd1;
            end
        end
    end

    assign buffer_count   = buffer_count_reg;
    assign int_count      = int_count_reg;
    assign irq            = (state_reg == ST_BUF_DONE) && set_int_reg;
    assign busy           = (state_reg != ST_IDLE);
    assign rd_cmd_valid   = (state_reg == ST_RD_CMD);
    assign wr_cmd_valid   = (state_reg == ST_WR_CMD);
    assign rd_cmd_len     = burst_len;
    assign wr_cmd_len     = burst_len;
    assign cmd_fetch_req  = (state_reg == ST_FETCH);
    assign cmd_fetch_addr = {next_addr_reg, {DESC_ALIGN_SHIFT{1'b0}}};

endmodule

// File: tb/tb_dma_ch_ctrl.sv
// Directed bench for dma_ch_ctrl: single/multi-burst buffers, interrupts,
// descriptor chaining, backpressure, zero-size buffers and mid-run reset.
module tb_dma_ch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] rd_start_addr = '0;
    logic [31:0] wr_start_addr = '0;
    logic [31:0] buffer_size = '0;
    logic        set_int = 1'b0;
    logic        cmd_last = 1'b0;
    logic [27:0] next_addr = '0;
    logic        wr_ch_start = 1'b0;
    logic [15:0] buffer_count;
    logic [15:0] int_count;
    logic        irq;
    logic        busy;
    logic        rd_cmd_valid;
    logic        rd_cmd_ready = 1'b0;
    logic [31:0] rd_cmd_addr;
    logic [8:0]  rd_cmd_len;
    logic        wr_cmd_valid;
    logic        wr_cmd_ready = 1'b0;
    logic [31:0] wr_cmd_addr;
    logic [8:0]  wr_cmd_len;
    logic        wr_done = 1'b0;
    logic        cmd_fetch_req;
    logic [31:0] cmd_fetch_addr;
    logic        cmd_fetch_ack = 1'b0;

    int errors = 0;
    int checks = 0;
    int exp_buf = 0;
    int exp_int = 0;

    always #5 clk = ~clk;

    dma_ch_ctrl #(.MAX_BURST(16), .BEAT_BYTES(4), .LEN_W(9)) dut (
        .clk            (clk),
        .reset          (reset),
        .rd_start_addr  (rd_start_addr),
        .wr_start_addr  (wr_start_addr),
        .buffer_size    (buffer_size),
        .set_int        (set_int),
        .cmd_last       (cmd_last),
        .next_addr      (next_addr),
        .wr_ch_start    (wr_ch_start),
        .buffer_count   (buffer_count),
        .int_count      (int_count),
        .irq            (irq),
        .busy           (busy),
        .rd_cmd_valid   (rd_cmd_valid),
        .rd_cmd_ready   (rd_cmd_ready),
        .rd_cmd_addr    (rd_cmd_addr),
        .rd_cmd_len     (rd_cmd_len),
        .wr_cmd_valid   (wr_cmd_valid),
        .wr_cmd_ready   (wr_cmd_ready),
        .wr_cmd_addr    (wr_cmd_addr),
        .wr_cmd_len     (wr_cmd_len),
        .wr_done        (wr_done),
        .cmd_fetch_req  (cmd_fetch_req),
        .cmd_fetch_addr (cmd_fetch_addr),
        .cmd_fetch_ack  (cmd_fetch_ack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [31:0] rd, input logic [31:0] wr, input logic [31:0] size,
                         input logic si, input logic last, input logic [27:0] nxt);
        rd_start_addr = rd;
        wr_start_addr = wr;
        buffer_size   = size;
        set_int       = si;
        cmd_last      = last;
        next_addr     = nxt;
        wr_ch_start   = 1'b1;
        tick();
        wr_ch_start   = 1'b0;
    endtask

    // One read + write command pair followed by a delayed wr_done pulse.
    task automatic do_burst(input string tag, input logic [31:0] rd, input logic [31:0] wr,
                            input logic [31:0] len);
        int n = 0;
        while (!rd_cmd_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, " rd_valid"}, 32'(rd_cmd_valid), 32'd1);
        check({tag, " rd_addr"}, rd_cmd_addr, rd);
        check({tag, " rd_len"}, 32'(rd_cmd_len), len);
        rd_cmd_ready = 1'b1;
        tick();
        rd_cmd_ready = 1'b0;
        check({tag, " wr_valid"}, 32'(wr_cmd_valid), 32'd1);
        check({tag, " wr_addr"}, wr_cmd_addr, wr);
        check({tag, " wr_len"}, 32'(wr_cmd_len), len);
        wr_cmd_ready = 1'b1;
        tick();
        wr_cmd_ready = 1'b0;
        tick();
        tick();
        check({tag, " wait no valid"}, 32'({rd_cmd_valid, wr_cmd_valid}), 32'd0);
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
    endtask

    // Called in the BUF_DONE cycle; leaves the bench one cycle later.
    task automatic finish_buf(input string tag, input logic exp_irq);
        check({tag, " irq"}, 32'(irq), 32'(exp_irq));
        check({tag, " cnt before"}, 32'(buffer_count), 32'(exp_buf));
        exp_buf++;
        if (exp_irq) exp_int++;
        tick();
        check({tag, " irq low"}, 32'(irq), 32'd0);
        check({tag, " buffer_count"}, 32'(buffer_count), 32'(exp_buf));
        check({tag, " int_count"}, 32'(int_count), 32'(exp_int));
    endtask

    initial begin
        int n;
        #12;
        check("reset busy", 32'(busy), 32'd0);
        check("reset counts", {buffer_count, int_count}, 32'd0);
        check("reset fetch", {31'd0, cmd_fetch_req} | cmd_fetch_addr, 32'd0);
        reset = 1'b1;
        tick();

        // Single 16-beat buffer, last in chain.
        start(32'h1000, 32'h2000, 32'd64, 1'b0, 1'b1, 28'h0);
        check("t1 latency rd_valid", 32'(rd_cmd_valid), 32'd1);
        do_burst("t1", 32'h1000, 32'h2000, 32'd16);
        finish_buf("t1", 1'b0);
        check("t1 busy", 32'(busy), 32'd0);

        // 36 beats -> 16,16,4.
        start(32'h1000, 32'h2000, 32'h90, 1'b0, 1'b1, 28'h0);
        do_burst("t2a", 32'h1000, 32'h2000, 32'd16);
        do_burst("t2b", 32'h1040, 32'h2040, 32'd16);
        do_burst("t2c", 32'h1080, 32'h2080, 32'd4);
        finish_buf("t2", 1'b0);

        // Interrupting buffer, then a non-interrupting one.
        start(32'h5000, 32'h6000, 32'd8, 1'b1, 1'b1, 28'h0);
        do_burst("t3", 32'h5000, 32'h6000, 32'd2);
        finish_buf("t3", 1'b1);
        start(32'h5000, 32'h6000, 32'd6, 1'b0, 1'b1, 28'h0);
        do_burst("t3b", 32'h5000, 32'h6000, 32'd1);
        finish_buf("t3b", 1'b0);

        // Chain: fetch ack in IDLE ignored, then a chained descriptor.
        cmd_fetch_ack = 1'b1;
        tick();
        cmd_fetch_ack = 1'b0;
        check("t4 stray ack", 32'(busy), 32'd0);
        start(32'h100, 32'h200, 32'd4, 1'b0, 1'b0, 28'h0000123);
        do_burst("t4a", 32'h100, 32'h200, 32'd1);
        finish_buf("t4a", 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("t4 fetch_req", 32'(cmd_fetch_req), 32'd1);
            check("t4 fetch_addr", cmd_fetch_addr, 32'h0000_1230);
            tick();
        end
        rd_start_addr = 32'h3000;
        wr_start_addr = 32'h4000;
        buffer_size   = 32'd4;
        cmd_last      = 1'b1;
        cmd_fetch_ack = 1'b1;
        tick();
        cmd_fetch_ack = 1'b0;
        check("t4 load state", 32'({busy, cmd_fetch_req, rd_cmd_valid}), 32'b100);
        do_burst("t4b", 32'h3000, 32'h4000, 32'd1);
        finish_buf("t4b", 1'b0);

        // Read backpressure with stray start and wr_done pulses.
        start(32'hA000, 32'hB000, 32'd40, 1'b0, 1'b1, 28'h0);
        for (int i = 0; i < 5; i++) begin
            wr_ch_start   = (i == 1);
            wr_done       = (i == 3);
            rd_start_addr = 32'hDEAD0000;
            buffer_size   = 32'd0;
            check("t5 stall valid", 32'(rd_cmd_valid), 32'd1);
            check("t5 stall addr", rd_cmd_addr, 32'hA000);
            check("t5 stall len", 32'(rd_cmd_len), 32'd10);
            tick();
        end
        wr_ch_start = 1'b0;
        wr_done     = 1'b0;
        do_burst("t5", 32'hA000, 32'hB000, 32'd10);
        finish_buf("t5", 1'b0);

        // Zero-size buffer.
        start(32'h0, 32'h0, 32'd3, 1'b0, 1'b1, 28'h0);
        check("t6 no cmd", 32'({rd_cmd_valid, wr_cmd_valid}), 32'd0);
        check("t6 busy", 32'(busy), 32'd1);
        finish_buf("t6", 1'b0);

        // Asynchronous reset while a write command is pending.
        start(32'h1000, 32'h2000, 32'd64, 1'b1, 1'b1, 28'h0);
        rd_cmd_ready = 1'b1;
        tick();
        rd_cmd_ready = 1'b0;
        check("t7 in wr_cmd", 32'(wr_cmd_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("t7 async valid", 32'({rd_cmd_valid, wr_cmd_valid, cmd_fetch_req, irq}), 32'd0);
        check("t7 counts", {buffer_count, int_count}, 32'd0);
        check("t7 busy", 32'(busy), 32'd0);
        tick();
        reset = 1'b1;
        n = 0;
        repeat (2) begin
            tick();
            n++;
        end
        check("t7 idle after release", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dma_ch_ctrl.md
Name: dma_ch_ctrl

Overview:
Channel sequencer directly downstream of DMA_regfile. It consumes the programmed descriptor (rd_start_addr, wr_start_addr, buffer_size, set_int, cmd_last, next_addr, wr_ch_start) and splits each buffer into bounded read/write burst commands for the datapath engines. It follows descriptor chains through next_addr and returns buffer_count/int_count status to the regfile.

Parameters:
MAX_BURST, 16, maximum beats per burst command (power of two, 2..256)
BEAT_BYTES, 4, bytes per beat (fixed 32-bit datapath)
LEN_W, 9, width of burst length fields (>= log2(MAX_BURST)+1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset asserted)
rd_start_addr  in  32  source byte address of current descriptor
wr_start_addr  in  32  destination byte address of current descriptor
buffer_size  in  32  transfer size in bytes; bits [1:0] ignored
set_int  in  1  raise interrupt when this buffer completes
cmd_last  in  1  descriptor is last in chain
next_addr  in  28  next descriptor address, 16-byte aligned (bits [31:4])
wr_ch_start  in  1  one-cycle start pulse from regfile
buffer_count  out  16  completed-buffer counter to regfile
int_count  out  16  interrupt-event counter to regfile
irq  out  1  one-cycle pulse per interrupting buffer completion
busy  out  1  high in every state except IDLE
rd_cmd_valid  out  1  read burst command valid
rd_cmd_ready  in  1  read engine accepts command
rd_cmd_addr  out  32  read burst byte address
rd_cmd_len  out  LEN_W  read burst length in beats (1..MAX_BURST)
wr_cmd_valid  out  1  write burst command valid
wr_cmd_ready  in  1  write engine accepts command
wr_cmd_addr  out  32  write burst byte address
wr_cmd_len  out  LEN_W  write burst length in beats
wr_done  in  1  one-cycle pulse: last issued write burst completed
cmd_fetch_req  out  1  request regfile reload from descriptor memory
cmd_fetch_addr  out  32  {next_addr latched, 4'b0000}
cmd_fetch_ack  in  1  one-cycle pulse: regfile registers reloaded

Behaviour:
- Reset: all outputs 0, state IDLE, internal registers 0. Reset mid-operation aborts immediately; valids and cmd_fetch_req drop asynchronously.
- States: IDLE, LOAD, RD_CMD, WR_CMD, WAIT_DONE, BUF_DONE, FETCH.
- IDLE: on wr_ch_start=1 at an edge, latch rd/wr addresses, remaining_beats = buffer_size[31:2], set_int, cmd_last, next_addr -> RD_CMD (rd_cmd_valid high the next cycle). If remaining_beats=0 -> BUF_DONE, no commands issued.
- wr_ch_start outside IDLE is ignored.
- RD_CMD: burst_len = min(remaining_beats, MAX_BURST); rd_cmd_valid=1, addr/len stable until rd_cmd_valid&rd_cmd_ready at an edge -> WR_CMD.
- WR_CMD: same handshake on write channel with the same burst_len -> WAIT_DONE.
- WAIT_DONE: on wr_done: both addresses += burst_len*BEAT_BYTES (32-bit wrap), remaining_beats -= burst_len; remaining>0 -> RD_CMD, else -> BUF_DONE. wr_done in any other state is ignored.
- BUF_DONE (one cycle): buffer_count += 1; if set_int latched: int_count += 1 and irq=1 this cycle. Both counters wrap 0xFFFF->0x0000 and clear only on reset. cmd_last latched=1 -> IDLE, else -> FETCH.
- FETCH: cmd_fetch_req=1, cmd_fetch_addr={next_addr,4'h0} held until cmd_fetch_ack -> LOAD. cmd_fetch_ack with cmd_fetch_req low is ignored.
- LOAD (one cycle, lets regfile outputs settle): latch descriptor inputs exactly as IDLE does -> RD_CMD, or BUF_DONE when size=0.
- Latency: wr_ch_start edge -> rd_cmd_valid next cycle; final wr_done -> buffer_count update 1 cycle later.
- Ready asserted in the same cycle valid rises is a legal single-cycle transfer.

Decomposition:
- Shared package dma_pkg: state encoding localparams, BEAT_BYTES, descriptor alignment shift (4).
- One sub-module dma_burst_split: combinational min(remaining, MAX_BURST) plus registered address/remaining update; the FSM and counters stay in dma_ch_ctrl.

Test Plan:
- rd=0x1000, wr=0x2000, size=64, cmd_last=1, start pulse -> one rd/wr command, addr 0x1000/0x2000, len 16; wr_done -> buffer_count=1, busy=0.
- size=0x90 (36 beats) -> bursts len 16,16,4 at rd 0x1000,0x1040,0x1080 and wr 0x2000,0x2040,0x2080; buffer_count=1.
- set_int=1, size=8 -> rd/wr len 2; after wr_done irq pulses exactly 1 cycle, int_count=1. set_int=0 run -> int_count unchanged.
- cmd_last=0, next_addr=28'h0000123 -> after BUF_DONE, cmd_fetch_addr=0x00001230; ack plus new regfile values (size=4, cmd_last=1) -> one len-1 burst, buffer_count=2.
- rd_cmd_ready low 5 cycles -> rd_cmd_valid/addr/len stable throughout; extra wr_ch_start pulse while busy -> no effect.
- size=0 -> no commands, buffer_count=1. reset pulled low during WR_CMD -> all outputs 0, counters 0, IDLE after release.
